// File: rtl/mem_router.sv
// mem_router: single-master, N-slave memory-mapped router with one outstanding
// transaction, address-region decode, wait states, bus errors and slave timeout.
module mem_router #(
    parameter int unsigned              N_SLAVES = 2,
    parameter logic [32*N_SLAVES-1:0]   BASES    = {32'h0000_1000, 32'h0000_0000},
    parameter logic [32*N_SLAVES-1:0]   MASKS    = {32'hFFFF_F000, 32'hFFFF_F000},
    parameter int unsigned              TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic                     m_we,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_wstrb,
    output logic                     m_rvalid,
    output logic [31:0]              m_rdata,
    output logic                     m_err,
    output logic [7:0]               err_cnt,
    output logic [N_SLAVES-1:0]      s_sel,
    output logic                     s_we,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [32*N_SLAVES-1:0]   s_rdata,
    input  logic [N_SLAVES-1:0]      s_ready
);

    // Counter only has to reach TIMEOUT-1
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state_q, state_d;
    logic [N_SLAVES-1:0]   sel_q, sel_d;
    logic                  we_q, we_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  hit;
    logic [N_SLAVES-1:0]   hit_sel;
    logic                  sel_ready;
    logic [31:0]           sel_rdata;

    // Region decode of the incoming address; lowest matching index wins
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (!hit && ((m_addr & MASKS[32*i +: 32]) == BASES[32*i +: 32])) begin
                hit        = 1'b1;
                hit_sel[i] = 1'b1;
            end
        end
    end

    // Ready and read data of the currently selected slave only
    always_comb begin
        sel_ready = |(s_ready & sel_q);
        sel_rdata = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | s_rdata[32*i +: 32];
            end
        end
    end

    // Next-state and registered-output computation for the transaction FSM
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (m_valid) begin
                    we_d    = m_we;
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    wstrb_d = m_wstrb;
                    cnt_d   = '0;
                    if (hit) begin
                        state_d = BUSY;
                        sel_d   = hit_sel;
                    end else begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        rdata_d  = '0;
                        err_d    = 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            BUSY: begin
                // A ready on the final timeout cycle still completes normally
                if (sel_ready) begin
                    state_d  = RESP;
                    sel_d    = '0;
                    rvalid_d = 1'b1;
                    rdata_d  = we_q ? 32'h0 : sel_rdata;
                    err_d    = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d  = RESP;
                    sel_d    = '0;
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m_ready  = rst_n && (state_q == IDLE);
    assign m_rvalid = rvalid_q;
    assign m_rdata  = rdata_q;
    assign m_err    = err_q;
    assign err_cnt  = err_cnt_q;
    assign s_sel    = sel_q;
    assign s_we     = we_q;
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign s_wstrb  = wstrb_q;

endmodule

// File: tb/tb_mem_router.sv
// tb_mem_router: directed and randomized transactions against a transaction-level
// reference model (region lookup, latency and error rules computed directly).
module tb_mem_router;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_valid;
    logic        m_ready;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        m_err;
    logic [7:0]  err_cnt;
    logic [1:0]  s_sel;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [63:0] s_rdata;
    logic [1:0]  s_ready;

    logic [31:0] sd0, sd1;
    assign s_rdata = {sd1, sd0};

    int n_checks = 0;
    int n_pass   = 0;
    int model_ecnt = 0;

    logic [31:0] base_a [2] = '{32'h0000_0000, 32'h0000_1000};
    logic [31:0] mask_a [2] = '{32'hFFFF_F000, 32'hFFFF_F000};

    mem_router #(
        .N_SLAVES (2),
        .BASES    ({32'h0000_1000, 32'h0000_0000}),
        .MASKS    ({32'hFFFF_F000, 32'hFFFF_F000}),
        .TIMEOUT  (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .m_err    (m_err),
        .err_cnt  (err_cnt),
        .s_sel    (s_sel),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_rdata  (s_rdata),
        .s_ready  (s_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int find_region(input logic [31:0] a);
        for (int i = 0; i < 2; i++)
            if ((a & mask_a[i]) == base_a[i]) return i;
        return -1;
    endfunction

    // One transaction; the selected slave raises ready after w wait cycles.
    // Entered and left on a falling edge.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int w,
                          input logic [31:0] d0, input logic [31:0] d1);
        int          reg_i, exp_lat, exp_selc, lat, selc, k;
        logic        exp_err, got_err, done, bus_ok;
        logic [31:0] exp_rdata, got_rdata;
        logic [1:0]  exp_sel, rv_sel, noise;
        logic [7:0]  got_ecnt;

        sd0 = d0;
        sd1 = d1;
        reg_i = find_region(addr);
        exp_sel = (reg_i < 0) ? 2'b00 : 2'(1 << reg_i);
        if (reg_i < 0) begin
            exp_err = 1'b1; exp_lat = 1; exp_selc = 0;
        end else if (w < TO) begin
            exp_err = 1'b0; exp_lat = w + 2; exp_selc = w + 1;
        end else begin
            exp_err = 1'b1; exp_lat = TO + 1; exp_selc = TO;
        end
        exp_rdata = (exp_err || we) ? 32'h0 : ((reg_i == 0) ? d0 : d1);
        if (exp_err && model_ecnt < 255) model_ecnt++;

        check_eq("m_ready_idle", {31'b0, m_ready}, 32'd1);
        m_valid = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb;
        @(posedge clk);
        #1;
        // Scramble the master bus so only latched values can satisfy the checks
        m_valid = 1'b0; m_we = ~we; m_addr = $urandom; m_wdata = $urandom; m_wstrb = 4'($urandom);

        k = 0; done = 1'b0; selc = 0; bus_ok = 1'b1; lat = 0;
        got_rdata = 32'hX; got_err = 1'bX; got_ecnt = 8'hX; rv_sel = 2'bXX;
        while (!done && k < TO + 8) begin
            @(negedge clk);
            k++;
            noise = 2'($urandom);
            if (m_rvalid) begin
                done = 1'b1; lat = k; got_rdata = m_rdata; got_err = m_err;
                got_ecnt = err_cnt; rv_sel = s_sel;
                s_ready = noise;
            end else if (s_sel != 2'b00) begin
                selc++;
                if (s_sel !== exp_sel || s_we !== we || s_addr !== addr ||
                    s_wdata !== wdata || s_wstrb !== wstrb || m_ready !== 1'b0)
                    bus_ok = 1'b0;
                s_ready = ((selc == w + 1) ? s_sel : 2'b00) | (noise & ~s_sel);
            end else begin
                s_ready = noise;
            end
        end
        s_ready = 2'b00;

        check_eq("rvalid_seen", {31'b0, done}, 32'd1);
        check_eq("latency", lat, exp_lat);
        check_eq("sel_cycles", selc, exp_selc);
        check_eq("rdata", got_rdata, exp_rdata);
        check_eq("err", {31'b0, got_err}, {31'b0, exp_err});
        check_eq("err_cnt", {24'b0, got_ecnt}, model_ecnt);
        check_eq("resp_sel", {30'b0, rv_sel}, 32'd0);
        if (reg_i >= 0) check_eq("s_bus_stable", {31'b0, bus_ok}, 32'd1);
        @(negedge clk);
        check_eq("rvalid_pulse", {31'b0, m_rvalid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ok;
        logic        we;
        logic [31:0] addr;
        int          pick;

        rst_n = 1'b0; m_valid = 1'b1; m_we = 1'b0; m_addr = 32'h2000;
        m_wdata = 32'h0; m_wstrb = 4'h0; s_ready = 2'b11; sd0 = 32'h0; sd1 = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_m_ready", {31'b0, m_ready}, 32'd0);
        check_eq("rst_s_sel", {30'b0, s_sel}, 32'd0);
        check_eq("rst_rvalid", {31'b0, m_rvalid}, 32'd0);
        check_eq("rst_rdata", m_rdata, 32'd0);
        check_eq("rst_err", {31'b0, m_err}, 32'd0);
        check_eq("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        check_eq("rst_s_addr", s_addr, 32'd0);
        m_valid = 1'b0; s_ready = 2'b00; rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 32'hDEADBEEF, 32'h1111_2222);
        do_txn(1'b1, 32'h0000_1004, 32'h0000_00A5, 4'b0001, 3, 32'h3333_4444, 32'h5555_6666);
        do_txn(1'b0, 32'h0000_2000, 32'h0, 4'hF, 0, 32'h7777_8888, 32'h9999_AAAA);
        do_txn(1'b0, 32'h0000_0000, 32'h0, 4'hF, 100, 32'hCAFE_F00D, 32'h0);
        do_txn(1'b0, 32'h0000_0ABC, 32'h0, 4'hF, 3, 32'h1234_5678, 32'h0);
        do_txn(1'b0, 32'h0000_1FFC, 32'h0, 4'hF, TO, 32'h0, 32'h8765_4321);

        // Randomized mix of regions, directions and wait counts
        for (int n = 0; n < 80; n++) begin
            pick = $urandom_range(0, 2);
            addr = $urandom;
            if (pick == 0)      addr = {20'h00000, addr[11:0]};
            else if (pick == 1) addr = {20'h00001, addr[11:0]};
            else                addr = addr | 32'h0001_0000;
            we = 1'($urandom);
            do_txn(we, addr, $urandom, 4'($urandom), $urandom_range(0, TO + 2), $urandom, $urandom);
        end

        // Error counter saturation
        for (int n = 0; n < 300; n++)
            do_txn(1'($urandom), $urandom | 32'h0001_0000, $urandom, 4'hF, 0, $urandom, $urandom);
        check_eq("err_cnt_sat", {24'b0, err_cnt}, 32'd255);

        // Reset while BUSY: select drops, no response, counter clears
        m_valid = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0010; s_ready = 2'b00;
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        @(negedge clk);
        check_eq("busy_sel", {30'b0, s_sel}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_busy_sel", {30'b0, s_sel}, 32'd0);
        check_eq("rst_busy_rvalid", {31'b0, m_rvalid}, 32'd0);
        check_eq("rst_busy_err_cnt", {24'b0, err_cnt}, 32'd0);
        model_ecnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (m_rvalid !== 1'b0 || s_sel !== 2'b00) ok = 1'b0;
        end
        check_eq("post_rst_quiet", {31'b0, ok}, 32'd1);
        do_txn(1'b0, 32'h0000_3000, 32'h0, 4'hF, 0, 32'h0, 32'h0);
        do_txn(1'b0, 32'h0000_0044, 32'h0, 4'hF, 1, 32'hA5A5_5A5A, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_router.md
# mem_router

Single-master, N-slave memory-mapped bus router with a valid/ready handshake, parametrised address regions, wait-state support, bus-error response and a slave timeout. It sits between the core's load/store unit and the memory-mapped slaves (BRAM, GPIO/UART, future peripherals). It replaces the fixed two-way combinational BRAM/GPIO split with a registered, one-outstanding-transaction router.

## Interface
Parameters:
- N_SLAVES, 2: number of slave ports (1..8).
- BASES, {32'h0000_1000, 32'h0000_0000}: N_SLAVES×32 flattened region bases; slot i at [32*i+31:32*i].
- MASKS, {32'hFFFF_F000, 32'hFFFF_F000}: N_SLAVES×32 flattened region masks, same slotting.
- TIMEOUT, 255: maximum cycles a slave select is held without s_ready (≥1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- m_valid  in  1  master request valid.
- m_ready  out  1  router can accept a request.
- m_we  in  1  1 = store, 0 = load.
- m_addr  in  32  byte address.
- m_wdata  in  32  store data.
- m_wstrb  in  4  byte enables.
- m_rvalid  out  1  one-cycle response pulse (loads and stores).
- m_rdata  out  32  load data; 0 on error or store.
- m_err  out  1  response is a bus error; valid with m_rvalid.
- err_cnt  out  8  saturating count of error responses.
- s_sel  out  N_SLAVES  one-hot slave select.
- s_we, s_addr, s_wdata, s_wstrb  out  1/32/32/4  latched request, broadcast to all slaves.
- s_rdata  in  N_SLAVES×32  flattened slave read data.
- s_ready  in  N_SLAVES  slave done; only the selected bit is honoured.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: m_ready=1. On m_valid sampled high, latch m_we/m_addr/m_wdata/m_wstrb and decode.
- Decode: region i hits when (m_addr & MASK_i) == BASE_i. The lowest hit index wins on overlap.
- Decode outcome:
  - Hit: go to BUSY and set s_sel to the one-hot hit index. Clear the timeout counter.
  - No hit: go to RESP with err=1 and rdata=0. No slave is selected.
- BUSY: m_ready=0. s_sel and s_* are held stable. The counter increments each cycle that s_ready[i] is low.
  - s_ready[i] sampled high: capture the s_rdata slice i (forced to 0 for stores), err=0, go to RESP.
  - Counter == TIMEOUT-1 with s_ready[i] low: go to RESP with err=1 and rdata=0.
  - If s_ready arrives on the timeout cycle, ready wins.
- RESP: m_rvalid=1 for exactly one cycle with m_rdata/m_err. s_sel=0. Return to IDLE.
- m_valid outside IDLE is ignored. The master holds the request until the m_valid&m_ready handshake.
- err_cnt increments on each RESP with err=1 and saturates at 255.

## Timing
- Reset (rst_n low at an edge): state=IDLE, s_sel=0, m_rvalid=0, m_err=0, m_rdata=0, err_cnt=0, counter=0, s_* latches=0. m_ready is forced to 0 while rst_n is low.
- Reset mid-transaction: s_sel drops at that edge and no response is issued.
- Mapped access: handshake at edge T0. s_sel is high in cycle T0+1. If s_ready is high at T1, m_rvalid is high in cycle T1+1. Minimum latency is 2 cycles; each wait state adds 1.
- Unmapped access: m_rvalid=1 with m_err=1 in the cycle after T0 (1-cycle latency).
- Timeout: s_sel is held for exactly TIMEOUT cycles, then m_rvalid/m_err follow in the next cycle.
- Back-to-back: next acceptance is possible in the cycle after RESP. Throughput is at most 1 transaction per 3 cycles.
- Outputs m_rvalid, m_rdata, m_err, s_sel and s_* are registered. m_ready is decoded from state.

## Test plan
- Load 0x0000_0010 with slave 0 returning s_ready at once and s_rdata slice 0 = 0xDEADBEEF. Required: s_sel=2'b01 one cycle; m_rvalid 2 cycles after the handshake; m_rdata=0xDEADBEEF; m_err=0.
- Store 0x0000_1004, wdata 0x000000A5, wstrb 4'b0001, with slave 1 holding ready low 3 cycles. Required: s_sel=2'b10 for 4 cycles; s_wdata/s_wstrb stable throughout; m_rvalid with m_rdata=0 and m_err=0.
- Load 0x0000_2000 (unmapped). Required: s_sel never asserts; m_rvalid and m_err next cycle; m_rdata=0; err_cnt=1.
- TIMEOUT=4 and slave 0 never ready. Required: s_sel high exactly 4 cycles; then m_err=1 and m_rdata=0. A second run with s_ready on the 4th cycle returns data with m_err=0.
- 300 consecutive unmapped accesses. Required: err_cnt saturates at 255. Assert rst_n low during a BUSY cycle: required s_sel=0 next cycle, no m_rvalid, err_cnt=0.
